// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the live window of the store buffer.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PTRW-1:0]       rd_ptr,
    input  logic [PTRW:0]         count,
    input  logic [29:0]           waddr,
    output logic                  hit,
    output logic [31:0]           hit_data
);

    logic [PTRW-1:0] idx;

    // Walk oldest to youngest; a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTRW'(i);
            if (((PTRW+1)'(i) < count) && (entries[idx].waddr == waddr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: absorbs core stores in one cycle, drains them in order
// to a handshaked RAM port, and forwards buffered data to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] ram_rdata,
    output logic        empty
);

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    logic [PTRW-1:0]       wr_ptr, rd_ptr;
    logic [PTRW:0]         count;
    logic                  push, pop, hit;
    logic [31:0]           hit_data;
    sb_entry_t             head;
    logic                  unused_byte_sel;

    assign unused_byte_sel = ^cpu_addr[1:0];

    // Full stalls on start-of-cycle count only, so a same-cycle pop never
    // creates a combinational path from mem_ready to stall.
    assign stall     = cpu_we && (count == FULL_CNT);
    assign push      = cpu_we && (count != FULL_CNT);
    assign mem_valid = (count != '0);
    assign empty     = (count == '0);
    assign pop       = mem_valid && mem_ready;

    assign head      = entries[rd_ptr];
    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_wdata = head.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload is don't-care while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{waddr: cpu_addr[31:2], data: cpu_wdata};
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .PTRW(PTRW)) u_fwd (
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .waddr    (cpu_addr[31:2]),
        .hit      (hit),
        .hit_data (hit_data)
    );

    assign cpu_rdata = (!cpu_we && hit) ? hit_data : ram_rdata;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a data RAM that accepts writes through a valid/ready handshake and may take several cycles per write. Core stores are absorbed in one cycle and drained in program order. Core loads read the RAM combinationally, with the youngest matching buffered store forwarded in place of the RAM value. The core's next-PC register consumes `stall`; when `stall` is high it must hold PC and suppress register writes.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, ≥2.
- `PTRW`, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `cpu_we` input 1: core store request this cycle (`MemWrite`).
- `cpu_addr` input 32: core byte address (`ALUResult`); bits [1:0] ignored.
- `cpu_wdata` input 32: core store data (`WriteData`).
- `cpu_rdata` output 32: load data to core (`ReadData`); combinational.
- `stall` output 1: store not accepted; the core must hold PC.
- `mem_valid` output 1: head entry offered to the RAM.
- `mem_ready` input 1: RAM accepts the head entry this cycle.
- `mem_addr` output 32: head word address; bits [1:0] = 00.
- `mem_wdata` output 32: head store data.
- `ram_rdata` input 32: RAM combinational read of `cpu_addr`.
- `empty` output 1: no entries buffered.

## Operation
- Storage: circular array of `DEPTH` entries, each {word address [31:2], data [31:0]}. State is `wr_ptr`, `rd_ptr` (PTRW bits, wrap modulo DEPTH) and `count` (PTRW+1 bits, range 0..DEPTH).
- Push: when `cpu_we` and `count != DEPTH`, write {cpu_addr[31:2], cpu_wdata} at `wr_ptr`, then `wr_ptr++`.
- Pop: when `mem_valid && mem_ready`, `rd_ptr++`.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- `stall = cpu_we && count == DEPTH`. This is pure combinational and does not depend on `mem_ready`. A full buffer stalls the store even if a pop occurs in the same cycle. The store is accepted on the first cycle where the start-of-cycle `count` is below DEPTH.
- `mem_valid = (count != 0)`. `mem_addr = {head.addr, 2'b00}`, `mem_wdata = head.data`.
- Once `mem_valid` is high, `mem_addr` and `mem_wdata` hold stable until accepted. Accepted entries reach the RAM strictly in push order.
- No coalescing: repeated stores to the same word each occupy an entry and each reach the RAM.
- Forwarding, when `cpu_we = 0`:
  - Compare `cpu_addr[31:2]` against every valid entry (the `count` entries from `rd_ptr`).
  - `cpu_rdata` = data of the youngest matching entry (closest to `wr_ptr`).
  - With no match, `cpu_rdata = ram_rdata`.
  - The head entry being popped this cycle still forwards.
- When `cpu_we = 1`, `cpu_rdata = ram_rdata`; the core ignores it.
- `empty = (count == 0)`.

## Timing
- Reset (async, any time): `count`, `wr_ptr`, `rd_ptr` go to 0 immediately.
  - Outputs become `mem_valid = 0`, `empty = 1`, `stall = 0`.
  - Buffered stores are discarded, including a head mid-handshake.
  - Entry contents are not reset; they are don't-care while invalid.
- Store latency: a pushed entry is visible on `mem_valid` the cycle after the push edge. With `mem_ready` tied high, it reaches the RAM one cycle after the push.
- Forwarding latency: zero. A load in the cycle right after a store sees that store's data.
- Throughput: one push and one pop per cycle sustained.
- `mem_ready` while `mem_valid = 0` is ignored.

## Structure
- Package `store_buffer_pkg`: typedef `sb_entry_t` packed {logic [29:0] waddr; logic [31:0] data}. Also localparam `SB_DEPTH_DEFAULT = 4`.
- One sub-module: `sb_fwd_match`, the combinational youngest-match priority search. Inputs are the entry array, `rd_ptr`, `count` and the lookup address. Outputs are `hit` and `hit_data`.
- Top level holds pointers, counter, storage array and output muxing.

## Test plan
- Drain with `mem_ready` = 1: store 0x64←7, then 0x60←3 → `mem_valid` on the next two cycles with (0x64,7) then (0x60,3); `empty` = 1 afterward.
- Fill with `mem_ready` = 0: four stores to 0x00, 0x04, 0x08, 0x0C, then a fifth store to 0x10 → `stall` = 1 on the fifth. Raise `mem_ready` one cycle → `stall` still 1 that cycle. Store accepted the next cycle. Drain order is 0x00, 0x04, 0x08, 0x0C, 0x10.
- Youngest-wins forwarding: with `mem_ready` = 0, store 0x20←0xAA, then 0x20←0xBB. Load 0x20 with `ram_rdata` = 0x55 → `cpu_rdata` = 0xBB. Load 0x24 → 0x55.
- Simultaneous push and pop at `count` = 2 → `count` stays 2, pointers both advance. Also wrap case: 9 stores with `mem_ready` toggling → RAM sees all 9 in order.
- Reset mid-handshake: `count` = 3, `mem_valid` = 1, `mem_ready` = 0, assert `reset` between edges → `mem_valid` = 0 and `empty` = 1 immediately. After reset, a load of a previously buffered address returns `ram_rdata`.
